scan_sequencer: RTL

Parametrised time-multiplexed display scanner. It drives N digit-select lines one at a time and routes the matching segment word to a shared segment bus. It adds four things a fixed free-running 2-bit decode does not have: programmable dwell time, a blanking gap between digits (anti-ghosting), per-digit enable mask with skipping, and a frame-complete pulse. It sits between the coffee-machine display formatter and the board's digit/segment pins.

---
 rtl/scan_sequencer_if.sv | 27 ++
 rtl/scan_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer_if.sv
// Bus bundle between the display formatter and the digit scanner.
// The formatter side (master) drives enable, mask and segment words;
// the scanner side (slave) drives the digit selects, segment bus,
// current index and frame pulse.
interface scan_sequencer_if #(
  parameter int N_DIGITS = 4,
  parameter int SEG_W    = 7,
  parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
);
  logic                      en;
  logic [N_DIGITS-1:0]       digit_mask;
  logic [N_DIGITS*SEG_W-1:0] seg_in;
  logic [N_DIGITS-1:0]       sel;
  logic [SEG_W-1:0]          seg_out;
  logic [IDX_W-1:0]          idx;
  logic                      frame_tick;

  modport master (
    output en, digit_mask, seg_in,
    input  sel, seg_out, idx, frame_tick
  );

  modport slave (
    input  en, digit_mask, seg_in,
    output sel, seg_out, idx, frame_tick
  );
endinterface

// File: rtl/scan_sequencer.sv
// Time-multiplexed display scanner. Walks the enabled digits in ascending
// order, showing each for DWELL cycles with a BLANK-cycle dark gap before
// every digit to stop ghosting between neighbours. A one-cycle frame pulse
// marks each wrap back to the lowest enabled digit. All outputs are
// registered and change together on the same edge.
module scan_sequencer #(
  parameter int N_DIGITS       = 4,
  parameter int SEG_W          = 7,
  parameter int DWELL          = 50000,
  parameter int BLANK          = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic            clk,
  input logic            rst,
  scan_sequencer_if.slave bus
);

  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam bit               HAS_BLANK  = (BLANK > 0);

  localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]    SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // A new digit is always entered through the dark gap, unless it has zero length.
  localparam state_t ENTRY_STATE = HAS_BLANK ? ST_BLANK : ST_SHOW;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_d;

  logic [IDX_W-1:0]   first_any;
  logic               any_set;
  logic [IDX_W-1:0]   first_above;
  logic               above_set;

  logic [N_DIGITS-1:0] sel_d;
  logic [SEG_W-1:0]    seg_word;
  logic [SEG_W-1:0]    seg_d;

  // Find the lowest enabled digit overall and the lowest enabled digit above the current one.
  always_comb begin
    first_any   = '0;
    any_set     = 1'b0;
    first_above = '0;
    above_set   = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (bus.digit_mask[i]) begin
        first_any = IDX_W'(i);
        any_set   = 1'b1;
        if (i > int'(idx_q)) begin
          first_above = IDX_W'(i);
          above_set   = 1'b1;
        end
      end
    end
  end

  // Sequencing decisions: dwell/blank timing, digit advance with wrap detection, enable handling.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (!bus.en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_set) begin
            state_d = ENTRY_STATE;
            idx_d   = first_any;
            cnt_d   = '0;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (!any_set) begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end else if (above_set) begin
              state_d = ENTRY_STATE;
              idx_d   = first_above;
            end else begin
              state_d = ENTRY_STATE;
              idx_d   = first_any;
              tick_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Build the next select and segment words from the upcoming state so pins track the state with no lag.
  always_comb begin
    seg_word = '0;
    sel_d    = SEL_OFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        seg_word = bus.seg_in[i*SEG_W +: SEG_W];
        if (state_d == ST_SHOW) begin
          sel_d[i] = ~SEL_ACTIVE_LOW;
        end
      end
    end
    seg_d = (state_d == ST_SHOW) ? (seg_word ^ SEG_OFF) : SEG_OFF;
  end

  // State, counter, index and all output pins, with synchronous reset to the dark idle condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      bus.sel        <= SEL_OFF;
      bus.seg_out    <= SEG_OFF;
      bus.idx        <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      bus.sel        <= sel_d;
      bus.seg_out    <= seg_d;
      bus.idx        <= idx_d;
      bus.frame_tick <= tick_d;
    end
  end

endmodule
